// File: rtl/clk_gen_pkg.sv
// Shared definitions for the multi-channel clock divider: state encoding,
// default field width and the period/high-time sanitiser.
package clk_gen_pkg;

    localparam int unsigned DIV_W_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_e;

    typedef struct packed {
        logic [31:0] p;
        logic [31:0] h;
    } div_cfg_t;

    // P = max(div, 2); H clamped to 1..P-1 so the output always toggles.
    function automatic div_cfg_t sanitise(input logic [31:0] d, input logic [31:0] h);
        div_cfg_t r;
        r.p = (d < 32'd2) ? 32'd2 : d;
        if (h < 32'd1) begin
            r.h = 32'd1;
        end else if (h > r.p - 32'd1) begin
            r.h = r.p - 32'd1;
        end else begin
            r.h = h;
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: IDLE/RUN control, period counter, latched P/H and
// registered clk_out/tick/active.
module clk_div_chan
    import clk_gen_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic [DIV_W-1:0] div,
    input  logic [DIV_W-1:0] hi,
    output logic             clk_out,
    output logic             tick,
    output logic             active
);

    chan_state_e      state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] pl_q, pl_d;
    logic [DIV_W-1:0] hl_q, hl_d;
    logic [DIV_W-1:0] cnt_inc;
    logic             clk_d, tick_d, active_d;
    logic             last;
    div_cfg_t         cfg;
    logic             cfg_unused;

    assign cfg        = sanitise(32'(div), 32'(hi));
    assign cfg_unused = ^{cfg.p[31:DIV_W], cfg.h[31:DIV_W]};
    assign cnt_inc    = cnt_q + DIV_W'(1);
    assign last       = (cnt_q == pl_q - DIV_W'(1));

    // Start (from IDLE, at a boundary, or on sync) takes priority over counting.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pl_d     = pl_q;
        hl_d     = hl_q;
        clk_d    = clk_out;
        tick_d   = 1'b0;
        active_d = active;
        if (en && (sync || state_q == ST_IDLE || last)) begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            pl_d     = cfg.p[DIV_W-1:0];
            hl_d     = cfg.h[DIV_W-1:0];
            clk_d    = 1'b1;
            tick_d   = 1'b1;
            active_d = 1'b1;
        end else if (state_q == ST_RUN) begin
            if (last) begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                clk_d    = 1'b0;
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_inc;
                clk_d = (cnt_inc < hl_q);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pl_q    <= DIV_W'(2);
            hl_q    <= DIV_W'(1);
            clk_out <= 1'b0;
            tick    <= 1'b0;
            active  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pl_q    <= pl_d;
            hl_q    <= hl_d;
            clk_out <= clk_d;
            tick    <= tick_d;
            active  <= active_d;
        end
    end

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider; N_CH independent channels sharing
// clk_in, rst and the phase-align sync pulse.
module clk_div_gen
    import clk_gen_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [N_CH-1:0]       en,
    input  logic [N_CH*DIV_W-1:0] div,
    input  logic [N_CH*DIV_W-1:0] hi,
    input  logic                  sync,
    output logic [N_CH-1:0]       clk_out,
    output logic [N_CH-1:0]       tick,
    output logic [N_CH-1:0]       active
);

    for (genvar c = 0; c < int'(N_CH); c++) begin : g_ch
        clk_div_chan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .clk_in (clk_in),
            .rst    (rst),
            .en     (en[c]),
            .sync   (sync),
            .div    (div[c*DIV_W +: DIV_W]),
            .hi     (hi[c*DIV_W +: DIV_W]),
            .clk_out(clk_out[c]),
            .tick   (tick[c]),
            .active (active[c])
        );
    end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Parametrised multi-channel clock divider that derives `N_CH` independent, glitch-free divided clocks from the single `clk_in` domain. Each channel has its own run-time period, high time and enable. It replaces the single-output `clk_gen` enable-gated generator and adds programmable ratio and duty cycle, period-boundary enable and ratio changes, a per-period tick strobe and a global phase-align input. The block sits at the top of the timing tree and feeds peripheral sample strobes and low-rate interface clocks.

## Interface
- `N_CH`, default 4: number of independent channels.
- `DIV_W`, default 8: width of the period and high-time fields.

- `clk_in`  in  1  the single clock; every register uses its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `en`  in  N_CH  per-channel run enable.
- `div`  in  N_CH*DIV_W  per-channel period P in `clk_in` cycles; channel c uses bits [c*DIV_W +: DIV_W].
- `hi`  in  N_CH*DIV_W  per-channel high time H in `clk_in` cycles; same packing as `div`.
- `sync`  in  1  one-cycle pulse that restarts the phase of every enabled channel.
- `clk_out`  out  N_CH  divided clock outputs, registered.
- `tick`  out  N_CH  one-cycle pulse in the cycle each `clk_out` period starts.
- `active`  out  N_CH  channel is running.

## Operation
- Each channel has two states, IDLE and RUN, plus a counter `cnt[DIV_W-1:0]` and latched copies Pl and Hl.
- Sanitising is applied whenever Pl and Hl are loaded:
  - P = max(`div`, 2).
  - H = `hi` clamped to the range 1..P-1.
  - The output therefore always toggles, with no stuck-high or stuck-low output.
- IDLE with `en[c]`=1:
  - Load Pl and Hl, set `cnt`=0.
  - Set `clk_out`=1, `tick`=1, `active`=1, and go to RUN.
- RUN with `cnt` < Pl-1:
  - `cnt`++ and `clk_out` <= (`cnt`+1 < Hl).
  - `tick`=0.
- RUN with `cnt` == Pl-1 (period boundary):
  - If `en[c]`=1: reload Pl and Hl from the inputs, set `cnt`=0, `clk_out`=1, `tick`=1.
  - If `en[c]`=0: set `cnt`=0, `clk_out`=0, `active`=0, and go to IDLE.
- `div` and `hi` changes made mid-period have no effect until the next boundary, so no runt pulses occur.
- Dropping `en` mid-period completes the current period; the output never truncates.
- `sync`=1 acts on every channel with `en[c]`=1, in either state:
  - Behaves like an IDLE start: reload, `cnt`=0, `clk_out`=1, `tick`=1, `active`=1.
  - Takes priority over normal counting and over the boundary logic.
- `sync`=1 does not affect channels with `en[c]`=0. A running channel with `en[c]`=0 continues its wind-down.
- Channels are fully independent except for `sync`.

## Timing
- Reset: every `cnt`=0, Pl=2, Hl=1, state IDLE, and `clk_out`, `tick`, `active` all 0.
- Reset has priority over `sync` and `en`.
- Asserting `rst` mid-period forces the reset values at the next edge, even if that truncates the current pulse.
- Start latency: `en` sampled high at edge k, with the channel IDLE, gives `clk_out`=1 and `tick`=1 visible after edge k.
- Steady state:
  - The period is exactly Pl cycles.
  - `clk_out` is high for exactly Hl cycles, starting at the `tick` cycle.
  - `tick` repeats every Pl cycles.
- Stop: after `en` falls, `clk_out` stays low from the end of the current period. `active` falls in the same cycle as the final boundary.
- `en` re-asserted in the same cycle as the final boundary means the channel continues with no gap, because the boundary samples `en`.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package `clk_gen_pkg` holds:
  - the state encoding `ST_IDLE`/`ST_RUN`;
  - the default `DIV_W`;
  - a sanitise function returning the clamped P and H.
- Sub-module `clk_div_chan` holds one channel (state, counter, latches, output registers). `clk_div_gen` instantiates it `N_CH` times in a generate loop and broadcasts `clk_in`, `rst` and `sync` to every instance.
- Expected RTL size is about 150–250 lines in total.

## Test plan
- Basic ratio: ch0 with `div`=4, `hi`=2, `en`=1 after reset.
  - `clk_out` follows the pattern 1100 repeating.
  - `tick` occurs every 4th cycle.
  - The first high cycle comes one edge after `en`.
- Clamping, three cases on one channel:
  - `div`=0, `hi`=0 gives P=2, H=1 (pattern 10).
  - `div`=5, `hi`=9 gives H=4 (pattern 11110).
  - `div`=1 gives P=2.
- Mid-period change: ch1 running with `div`=6, `hi`=3. At `cnt`=2, change to `div`=3, `hi`=1.
  - The current period completes as 111000.
  - The next periods are 100.
  - No pulse shorter than 1 or longer than 3 high cycles appears.
- Enable drop and rejoin: ch2 with `div`=8, `hi`=4.
  - Drop `en` at `cnt`=1: the period finishes, then `clk_out`=0 and `active`=0 exactly 7 cycles later.
  - Re-assert `en` on the final boundary cycle: the channel runs with no gap.
- Sync alignment: ch0 with `div`=4 and ch1 with `div`=6, both running at arbitrary phase.
  - A `sync` pulse makes both `tick`s fire in the same cycle.
  - They coincide again after 12 cycles.
  - ch3 with `en`=0 stays idle throughout.
- Reset mid-period: ch0 high at `cnt`=1 when `rst`=1.
  - All outputs are 0 at the next edge.
  - After `rst` releases with `en`=1, the channel restarts at `cnt`=0 one edge later.
